// File: rtl/objects_mux_pkg.sv
// Shared constants and RRRGGGBB -> 24-bit colour expansion for the layered object mux.
package objects_mux_pkg;

    localparam int unsigned RGB_W = 8;
    localparam logic [RGB_W-1:0] TRANSPARENT_DEF = 8'hFF;
    localparam logic [RGB_W-1:0] BLACK = 8'h00;

    function automatic logic [7:0] expand_red(input logic [RGB_W-1:0] c);
        return {c[7:5], {5{c[5]}}};
    endfunction

    function automatic logic [7:0] expand_green(input logic [RGB_W-1:0] c);
        return {c[4:2], {5{c[2]}}};
    endfunction

    function automatic logic [7:0] expand_blue(input logic [RGB_W-1:0] c);
        return {c[1:0], {6{c[0]}}};
    endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational layer selection: marks opaque layers and picks the lowest-index one, else background.
module layer_priority_sel
    import objects_mux_pkg::*;
#(
    parameter int unsigned      NUM_LAYERS  = 4,
    parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic [NUM_LAYERS*RGB_W-1:0] i_layer_rgb,
    input  logic [NUM_LAYERS-1:0]       i_layer_req,
    input  logic [RGB_W-1:0]            i_bgr_rgb,
    output logic [RGB_W-1:0]            o_sel_rgb_c,
    output logic [NUM_LAYERS-1:0]       o_opaque_c
);

    always_comb begin
        o_opaque_c  = '0;
        o_sel_rgb_c = i_bgr_rgb;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            o_opaque_c[i] = i_layer_req[i] && (i_layer_rgb[i*RGB_W +: RGB_W] != TRANSPARENT);
        end
        // Walk from the lowest priority upwards so layer 0 is written last and wins.
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (o_opaque_c[i]) begin
                o_sel_rgb_c = i_layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

endmodule

// File: rtl/layered_objects_mux.sv
// Two-stage layered object compositor with per-frame collision reporting.
module layered_objects_mux
    import objects_mux_pkg::*;
#(
    parameter int unsigned      NUM_LAYERS  = 4,
    parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEF,
    parameter bit               COLL_EN     = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
    input  logic [NUM_LAYERS-1:0]       layerReq,
    input  logic [RGB_W-1:0]            bgrRGB,
    input  logic                        blank,
    input  logic                        startOfFrame,
    output logic [7:0]                  redOut,
    output logic [7:0]                  greenOut,
    output logic [7:0]                  blueOut,
    output logic [NUM_LAYERS-1:0]       collisionVec,
    output logic                        collisionPulse
);

    logic [RGB_W-1:0]      w_sel_rgb;
    logic [NUM_LAYERS-1:0] w_opaque;
    logic [NUM_LAYERS-1:0] w_hits;

    logic [RGB_W-1:0]      r_sel_rgb;
    logic [NUM_LAYERS-1:0] r_opaque;
    logic                  r_blank;
    logic                  r_sof;
    logic [7:0]            r_red;
    logic [7:0]            r_green;
    logic [7:0]            r_blue;

    layer_priority_sel #(
        .NUM_LAYERS  (NUM_LAYERS),
        .TRANSPARENT (TRANSPARENT)
    ) u_sel (
        .i_layer_rgb (layerRGB),
        .i_layer_req (layerReq),
        .i_bgr_rgb   (bgrRGB),
        .o_sel_rgb_c (w_sel_rgb),
        .o_opaque_c  (w_opaque)
    );

    // Stage 1: selected colour plus the side-band needed by collision logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_rgb <= '0;
            r_opaque  <= '0;
            r_blank   <= 1'b0;
            r_sof     <= 1'b0;
        end else begin
            r_sel_rgb <= blank ? BLACK : w_sel_rgb;
            r_opaque  <= w_opaque;
            r_blank   <= blank;
            r_sof     <= startOfFrame;
        end
    end

    // Stage 2: colour expansion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_red   <= expand_red(r_sel_rgb);
            r_green <= expand_green(r_sel_rgb);
            r_blue  <= expand_blue(r_sel_rgb);
        end
    end

    assign redOut   = r_red;
    assign greenOut = r_green;
    assign blueOut  = r_blue;

    // x & (x-1) is non-zero exactly when two or more layers are opaque.
    always_comb begin
        w_hits = '0;
        if (!r_blank && ((r_opaque & (r_opaque - NUM_LAYERS'(1))) != '0)) begin
            w_hits = r_opaque;
        end
    end

    generate
        if (COLL_EN) begin : g_coll
            logic [NUM_LAYERS-1:0] r_hit_acc;
            logic [NUM_LAYERS-1:0] r_coll_vec;
            logic                  r_coll_pulse;

            // Frame boundary: publish the finished frame, restart with this pixel's hits.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_hit_acc    <= '0;
                    r_coll_vec   <= '0;
                    r_coll_pulse <= 1'b0;
                end else if (r_sof) begin
                    r_hit_acc    <= w_hits;
                    r_coll_vec   <= r_hit_acc;
                    r_coll_pulse <= 1'b1;
                end else begin
                    r_hit_acc    <= r_hit_acc | w_hits;
                    r_coll_pulse <= 1'b0;
                end
            end

            assign collisionVec   = r_coll_vec;
            assign collisionPulse = r_coll_pulse;
        end else begin : g_no_coll
            assign collisionVec   = '0;
            assign collisionPulse = 1'b0;
        end
    endgenerate

endmodule
